// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use, branch redirect, I/D wait states, halt.
// Optional performance counters are enabled with `define PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       id_op,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [6:0]       ex_op,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {S_RUN, S_DMEM_WAIT, S_HALT} state_t;

  state_t          state_q;
  logic [WW-1:0]   wait_cnt_q;
  logic            mem_err_q;
  logic            freeze, lu, rs1_used, rs2_used, sys_halt;

  always_comb begin
    rs1_used = !(id_op == OP_LUI || id_op == OP_AUIPC || id_op == OP_JAL);
    rs2_used = (id_op == OP_BRANCH || id_op == OP_STORE || id_op == OP_OP);
    freeze   = mem_req && !mem_ready;
    lu       = (ex_op == OP_LOAD) && (ex_rd != 5'd0) &&
               ((ex_rd == id_rs1 && rs1_used) || (ex_rd == id_rs2 && rs2_used));
    sys_halt = (ex_op == OP_SYSTEM) && !branch_taken;
  end

  // Outputs are combinational so a stall bites in the cycle the hazard is seen.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (rst) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      {if_id_flush, id_ex_flush, mem_wb_flush}          = '1;
    end else if (state_q == S_HALT) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
    end else if (freeze) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en} = '0;
      mem_wb_flush = 1'b1;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (!imem_ready) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (freeze) begin
            state_q    <= S_DMEM_WAIT;
            wait_cnt_q <= WW'(1);
          end else if (sys_halt) begin
            state_q <= S_HALT;
          end
        end
        S_DMEM_WAIT: begin
          if (!freeze) begin
            // Completing cycle advances the pipe; a SYSTEM held in EX halts now.
            wait_cnt_q <= '0;
            state_q    <= sys_halt ? S_HALT : S_RUN;
          end else if (wait_cnt_q == WW'(MEM_TIMEOUT)) begin
            state_q   <= S_HALT;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WW'(1);
          end
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign halted  = (state_q == S_HALT);
  assign mem_err = mem_err_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en && state_q != S_HALT && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (state_q != S_HALT && !freeze && branch_taken && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Detects load-use hazards that forwarding cannot cover.
- Handles taken-branch redirects, instruction-fetch and data-memory wait states, and halting on SYSTEM instructions.
- Drives the per-stage enable and flush strobes of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. The forwarding unit runs alongside it.

Parameters:
- MEM_TIMEOUT, 16: maximum number of consecutive data-memory wait cycles before a fatal halt.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock; everything updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_op  in  7  opcode in IF/ID.
- id_rs1, id_rs2  in  5 each  source registers in IF/ID.
- ex_op  in  7  opcode in ID/EX.
- ex_rd  in  5  destination register in ID/EX.
- branch_taken  in  1  EX resolved a taken branch or jump (JAL/JALR/branch).
- imem_ready  in  1  instruction word valid this cycle.
- mem_req  in  1  MEM stage issues a load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register load enables.
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  insert a NOP bubble into that register.
- halted  out  1  core stopped (SYSTEM instruction or timeout).
- mem_err  out  1  sticky: data-memory timeout occurred.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters (optional feature).

Behaviour:
- Single clock. Reset is synchronous and active-high.
- While rst=1 (combinational override):
  - all *_en = 0, all *_flush = 1.
  - On the edge: state = RUN, wait_cnt = 0, halted = 0, mem_err = 0, counters = 0.
- FSM states RUN, DMEM_WAIT, HALT. Outputs are combinational from state and current inputs, so a stall acts in the same cycle.
- Conditions:
  - freeze = mem_req && !mem_ready.
  - lu = (ex_op == 0000011) && ex_rd != 0 && ((ex_rd == id_rs1 && id uses rs1) || (ex_rd == id_rs2 && id uses rs2)).
  - rs1 is used by every opcode except LUI 0110111, AUIPC 0010111 and JAL 1101111.
  - rs2 is used only by BRANCH 1100011, STORE 0100011 and OP 0110011.
- Default (RUN, no event): all en = 1, all flush = 0.
- Priority, highest first: HALT > freeze > branch_taken > lu > !imem_ready.
  1. HALT: all en = 0, all flush = 0, halted = 1. Exit only via rst.
  2. freeze:
     - pc/if_id/id_ex/ex_mem en = 0; mem_wb_en = 1 with mem_wb_flush = 1 (bubble into WB).
     - branch_taken and lu are ignored; the instruction in EX is held, so it re-asserts after the freeze.
  3. branch_taken: pc_en = 1, if_id_flush = 1, id_ex_flush = 1. This is a 2-cycle penalty; any concurrent lu is discarded because it is wrong-path.
  4. lu: pc_en = 0, if_id_en = 0, id_ex_flush = 1 (one bubble); later stages advance. After one cycle the load reaches MEM and lu clears by itself.
  5. !imem_ready: pc_en = 0, if_id_flush = 1; later stages advance.
- Transitions:
  - RUN -> DMEM_WAIT on freeze; wait_cnt = 1.
  - DMEM_WAIT with mem_ready = 1 -> RUN, wait_cnt = 0. The completing cycle is not frozen.
  - DMEM_WAIT, still waiting, wait_cnt < MEM_TIMEOUT: wait_cnt += 1.
  - DMEM_WAIT, still waiting, wait_cnt == MEM_TIMEOUT -> HALT, mem_err = 1.
  - RUN -> HALT when ex_op == 1110011 (SYSTEM), no freeze and no branch_taken. Halt takes effect next cycle; instructions already past EX do not complete.
- wait_cnt is $clog2(MEM_TIMEOUT+1) bits wide and never wraps.
- Reset in the middle of DMEM_WAIT or HALT returns to RUN on the next edge.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined:
  - stall_cnt += 1 each cycle pc_en = 0 while not in HALT and rst = 0.
  - flush_cnt += 1 each cycle branch_taken causes a flush.
  - Both saturate at all-ones and clear on rst.
- Undefined: stall_cnt and flush_cnt are tied to 0 and no counter flops are synthesized.

Test Plan:
- Load-use: ex_op = 0000011, ex_rd = 5, id_op = 0110011, id_rs2 = 5 -> one cycle of pc_en = 0, if_id_en = 0, id_ex_flush = 1. Same case with ex_rd = 0, or id_op = LUI -> no stall.
- Branch vs load-use: branch_taken = 1 together with an lu condition -> if_id_flush = id_ex_flush = 1, pc_en = 1, no stall.
- Data-memory wait: mem_req = 1, mem_ready = 0 for 3 cycles, then 1 -> 3 cycles with pc/if_id/id_ex/ex_mem en = 0 and mem_wb_flush = 1; state returns to RUN; stall_cnt = 3 with PIPE_CTRL_PERF_EN.
- Timeout: MEM_TIMEOUT = 4, mem_ready held at 0 -> HALT entered after 4 wait cycles, mem_err = 1, halted = 1; it holds until rst, then everything is 0 / RUN.
- SYSTEM halt: ex_op = 1110011 -> halted = 1 next cycle, all en = 0. With freeze asserted in the same cycle, halt is deferred until mem_ready.
- Fetch wait: imem_ready = 0 for 2 cycles -> pc_en = 0 and if_id_flush = 1 both cycles while ex_mem_en = 1.
